single_fm_log2: RTL and testbench

SINGLE_FM_LOG2 -- requirements
Module: single_fm_log2

---
 rtl/single_fm_log2.sv | 165 ++++++++++++++++
 tb/tb_single_fm_log2.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_fm_log2.sv
// single_fm_log2 -- iterative IEEE-754 single-precision log2.
//
// Computes c = log2(a) by repeated squaring of the mantissa: each ITER cycle
// squares m in 1.23 format and emits one fraction bit of log2(m). After
// FRAC_BITS iterations the signed fixed-point value {exponent, fraction} is
// normalised into a single-precision result in PACK. Special operands
// (zero/denormal, negative, inf, NaN) are classified at accept and override
// the computed value in PACK, so every operation has the same latency.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   operand a valid this cycle
//   in_ready   out  1   operand can be accepted this cycle (IDLE or DONE)
//   a          in  32   single-precision operand
//   out_valid  out  1   one-cycle pulse, c holds a new result
//   c          out 32   single-precision log2(a), held between results
module single_fm_log2 #(
  parameter int unsigned FRAC_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  output logic [31:0] c
);

  localparam int unsigned VW = FRAC_BITS + 8;
  localparam int unsigned CW = $clog2(FRAC_BITS);
  localparam int unsigned LW = $clog2(VW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_PACK,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           exp_q, exp_d;
  logic [23:0]          m_q, m_d;
  logic [FRAC_BITS-1:0] f_q, f_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 spec_q, spec_d;
  logic [31:0]          spec_val_q, spec_val_d;
  logic [31:0]          c_q, c_d;

  logic                 accept;
  logic [24:0]          sq_hi;
  logic                 a_special;
  logic [31:0]          a_spec_val;

  logic [VW-1:0]        v;
  logic                 v_neg;
  logic [VW-1:0]        mag;
  logic [LW-1:0]        lead;
  logic [LW-1:0]        shamt;
  logic [22:0]          mant;
  logic [7:0]           expf;
  logic [31:0]          pack_val;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign c         = c_q;

  // Operand classification; priority makes any NaN (either sign) a quiet NaN
  // and lets -0 map to -inf like +0.
  always_comb begin
    a_special  = 1'b1;
    a_spec_val = '0;
    if (a[30:23] == 8'hFF && a[22:0] != '0) begin
      a_spec_val = 32'h7FC00000;
    end else if (a[30:23] == 8'h00) begin
      a_spec_val = 32'hFF800000;
    end else if (a[31]) begin
      a_spec_val = 32'h7FC00000;
    end else if (a[30:23] == 8'hFF) begin
      a_spec_val = 32'h7F800000;
    end else begin
      a_special  = 1'b0;
    end
  end

  // Normalise the signed fixed value {e, f} (binary point above f).
  always_comb begin
    v     = {exp_q, f_q};
    v_neg = v[VW-1];
    mag   = v_neg ? (~v + VW'(1)) : v;
    lead  = '0;
    for (int unsigned i = 0; i < VW; i++) begin
      if (mag[i]) lead = LW'(i);
    end
    shamt = LW'(VW - 1) - lead;
    // Leading one moved to bit VW-1; the 23 bits below it are the mantissa.
    mant  = 23'((mag << shamt) >> (VW - 24));
    expf  = 8'd127 + 8'(lead) - 8'(FRAC_BITS);
    pack_val = (mag == '0) ? 32'h00000000 : {v_neg, expf, mant};
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    m_d        = m_q;
    f_d        = f_q;
    cnt_d      = cnt_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    c_d        = c_q;
    // Only bits 47:23 of the 2.46 square are ever needed.
    sq_hi      = 25'((48'(m_q) * 48'(m_q)) >> 23);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          exp_d      = a[30:23] - 8'd127;
          m_d        = {1'b1, a[22:0]};
          f_d        = '0;
          cnt_d      = '0;
          spec_d     = a_special;
          spec_val_d = a_spec_val;
          state_d    = S_ITER;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        f_d   = {f_q[FRAC_BITS-2:0], sq_hi[24]};
        m_d   = sq_hi[24] ? sq_hi[24:1] : sq_hi[23:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(FRAC_BITS - 1)) state_d = S_PACK;
      end
      S_PACK: begin
        c_d     = spec_q ? spec_val_q : pack_val;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      exp_q      <= '0;
      m_q        <= '0;
      f_q        <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      c_q        <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      m_q        <= m_d;
      f_q        <= f_d;
      cnt_q      <= cnt_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      c_q        <= c_d;
    end
  end

endmodule

// File: tb/tb_single_fm_log2.sv
module tb_single_fm_log2;

  localparam int FRAC_BITS = 24;
  // out_valid is first seen after this many rising edges past the accept edge.
  localparam int LAT = FRAC_BITS + 1;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic [31:0] c;

  int tests_run;
  int fails;

  single_fm_log2 #(.FRAC_BITS(FRAC_BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .out_valid(out_valid),
    .c        (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Exact single-precision encoding of a small integer.
  function automatic logic [31:0] int_to_f32(input int k);
    int unsigned m;
    int msb;
    logic [31:0] sh;
    if (k == 0) return 32'h00000000;
    m = (k < 0) ? -k : k;
    msb = 0;
    for (int i = 0; i < 31; i++) if (((m >> i) & 1) == 1) msb = i;
    sh = m << (23 - msb);
    return {(k < 0), 8'(127 + msb), sh[22:0]};
  endfunction

  function automatic real f2r(input logic [31:0] b);
    real r;
    if (b[30:23] == 8'h00) return 0.0;
    r = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(int'(b[30:23]) - 127));
    return b[31] ? -r : r;
  endfunction

  function automatic real ulp_of(input real y);
    real r;
    int k;
    r = (y < 0.0) ? -y : y;
    k = 0;
    while (r >= 2.0) begin r = r / 2.0; k++; end
    while (r < 1.0)  begin r = r * 2.0; k--; end
    return 2.0 ** real'(k - 23);
  endfunction

  function automatic real log2_of(input logic [31:0] b);
    return $ln(f2r(b)) / $ln(2.0);
  endfunction

  // ---------------- stimulus helper ----------------
  // Issues one operand and waits (bounded) for its result; lat = -1 on timeout.
  task automatic run_op(input logic [31:0] op, output logic [31:0] res, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    a = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    lat = -1;
    res = 32'hxxxxxxxx;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        res = c;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    a = 32'h41000000;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b c=%h, want 1 0 00000000",
               in_ready, out_valid, c);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
      tests_run++;
      if (seen != 0 || c !== 32'h0) begin
        fails++;
        $display("FAIL reset_no_accept: out_valid pulses=%0d c=%h, want 0 00000000", seen, c);
      end
    end
  endtask

  task automatic test_pow2();
    logic [31:0] ops[5];
    logic [31:0] exp_c[5];
    logic [31:0] res;
    int lat;
    ops   = '{32'h3F800000, 32'h41000000, 32'h3F000000, 32'h00800000, 32'h7F000000};
    exp_c = '{32'h00000000, 32'h40400000, 32'hBF800000, 32'hC2FC0000, int_to_f32(127)};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], res, lat);
      tests_run++;
      if (res !== exp_c[i] || lat != LAT) begin
        fails++;
        $display("FAIL pow2[%h]: c=%h lat=%0d, want c=%h lat=%0d", ops[i], res, lat, exp_c[i], LAT);
      end
    end
    // random exact powers of two against the integer model
    for (int i = 0; i < 6; i++) begin
      int ex;
      ex = $urandom_range(1, 254);
      run_op({1'b0, 8'(ex), 23'd0}, res, lat);
      tests_run++;
      if (res !== int_to_f32(ex - 127) || lat != LAT) begin
        fails++;
        $display("FAIL pow2_rand[2^%0d]: c=%h lat=%0d, want c=%h lat=%0d",
                 ex - 127, res, lat, int_to_f32(ex - 127), LAT);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] ops[7];
    logic [31:0] exp_c[7];
    logic [31:0] res;
    int lat;
    ops   = '{32'h00000000, 32'h80000000, 32'h00012345, 32'hC0000000,
              32'h7F800000, 32'h7FC00001, 32'hFF800001};
    exp_c = '{32'hFF800000, 32'hFF800000, 32'hFF800000, 32'h7FC00000,
              32'h7F800000, 32'h7FC00000, 32'h7FC00000};
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], res, lat);
      tests_run++;
      if (res !== exp_c[i] || lat != LAT) begin
        fails++;
        $display("FAIL special[%h]: c=%h lat=%0d, want c=%h lat=%0d", ops[i], res, lat, exp_c[i], LAT);
      end
    end
  endtask

  task automatic test_accuracy();
    logic [31:0] ops[18];
    logic [31:0] res;
    int lat;
    real y, err;
    ops[0] = 32'h40400000;
    ops[1] = 32'h3E800001;
    // random normals whose log2 magnitude is at least 2
    for (int i = 2; i < 18; i++) begin
      int ex;
      ex = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 124) : $urandom_range(129, 254);
      ops[i] = {1'b0, 8'(ex), 23'($urandom)};
    end
    for (int i = 0; i < 18; i++) begin
      y = log2_of(ops[i]);
      run_op(ops[i], res, lat);
      err = f2r(res) - y;
      if (err < 0.0) err = -err;
      tests_run++;
      if (lat != LAT || err > 2.0 * ulp_of(y)) begin
        fails++;
        $display("FAIL accuracy[%h]: c=%h (%f) lat=%0d, want %f within 2 ulp lat=%0d",
                 ops[i], res, f2r(res), lat, y, LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops[4];
    logic [31:0] q[$];
    int idx, results, last_cyc;
    bit accept_now;
    for (int i = 0; i < 4; i++) ops[i] = {1'b0, 8'($urandom_range(100, 160)), 23'd0};
    idx = 0;
    results = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 300 && results < 4; cyc++) begin
      @(negedge clk);
      if (idx < 4) begin
        in_valid = 1'b1;
        a = in_ready ? ops[idx] : $urandom;
      end else begin
        in_valid = 1'b0;
        a = $urandom;
      end
      accept_now = in_ready && in_valid;
      @(posedge clk);
      if (accept_now) begin
        q.push_back(int_to_f32(int'(ops[idx][30:23]) - 127));
        idx++;
      end
      #1;
      if (out_valid) begin
        tests_run++;
        if (q.size() == 0 || c !== q[0]) begin
          fails++;
          $display("FAIL stream_value[%0d]: c=%h, want %h", results, c,
                   (q.size() == 0) ? 32'h0 : q[0]);
        end
        if (q.size() != 0) void'(q.pop_front());
        if (results > 0) begin
          tests_run++;
          if (cyc - last_cyc != FRAC_BITS + 2) begin
            fails++;
            $display("FAIL stream_spacing[%0d]: %0d cycles, want %0d", results,
                     cyc - last_cyc, FRAC_BITS + 2);
          end
        end
        last_cyc = cyc;
        results++;
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (results != 4) begin
      fails++;
      $display("FAIL stream_count: %0d results, want 4", results);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] res;
    int lat, seen;
    @(negedge clk);
    a = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 32'h0) begin
      fails++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b c=%h, want 1 0 00000000",
               in_ready, out_valid, c);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    tests_run++;
    if (seen != 0 || c !== 32'h0) begin
      fails++;
      $display("FAIL abort_no_result: out_valid pulses=%0d c=%h, want 0 00000000", seen, c);
    end
    run_op(32'h40800000, res, lat);
    tests_run++;
    if (res !== 32'h40000000 || lat != LAT) begin
      fails++;
      $display("FAIL abort_next[40800000]: c=%h lat=%0d, want c=40000000 lat=%0d", res, lat, LAT);
    end
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    test_reset();
    test_pow2();
    test_special();
    test_accuracy();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
